// File: rtl/ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ula_arbiter
// Desc     : Two-requester issue arbiter in front of one combinational ULA,
//            with registered S/Z/err and a per-requester response handshake.
//            Define ULA_ARB_FIXED_PRIO_EN for fixed priority (requester 0).
// Revision : 1.0  initial release
// ============================================================================
module ula_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_z,
  output logic             rsp_err,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [OP_W-1:0]  ula_op,
  input  logic [WIDTH-1:0] ula_s,
  input  logic             ula_z
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] c_op_and = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] c_op_or  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] c_op_add = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] c_op_sub = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] c_op_slt = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] c_op_nor = OP_W'(4'b1100);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_grant;
  logic             w_winner;
  logic             w_issue;
  logic [1:0]       w_req_ready;
  logic [WIDTH-1:0] r_ula_a;
  logic [WIDTH-1:0] r_ula_b;
  logic [OP_W-1:0]  r_ula_op;
  logic [WIDTH-1:0] r_rsp_s;
  logic             r_rsp_z;
  logic             r_rsp_err;

  function automatic logic f_illegal(input logic [OP_W-1:0] op);
    logic ill;
    case (op)
      c_op_and, c_op_or, c_op_add, c_op_sub, c_op_slt, c_op_nor: ill = 1'b0;
      default:                                                   ill = 1'b1;
    endcase
    return ill;
  endfunction

`ifdef ULA_ARB_FIXED_PRIO_EN
  // Requester 0 always wins a tie; requester 1 may starve.
  logic w_tie_winner;
  assign w_tie_winner = 1'b0;
`else
  // Requester that was served most recently; reset to 1 so 0 wins the first tie.
  logic r_rr_last;
  logic w_tie_winner;
  assign w_tie_winner = ~r_rr_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_last <= 1'b1;
    end else if (w_issue) begin
      r_rr_last <= w_winner;
    end
  end
`endif

  always_comb begin
    w_winner    = 1'b0;
    w_req_ready = 2'b00;
    if (r_state == S_IDLE) begin
      case (req_valid)
        2'b01:   w_winner = 1'b0;
        2'b10:   w_winner = 1'b1;
        2'b11:   w_winner = w_tie_winner;
        default: w_winner = 1'b0;
      endcase
      if (|req_valid) begin
        w_req_ready = w_winner ? 2'b10 : 2'b01;
      end
    end
  end

  assign w_issue = |w_req_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (rsp_ready[r_grant]) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The ULA operand registers double as the capture registers: loaded on
  // issue, presented during EXEC, and left untouched otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_ula_a   <= '0;
      r_ula_b   <= '0;
      r_ula_op  <= '0;
      r_rsp_s   <= '0;
      r_rsp_z   <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_grant  <= w_winner;
        r_ula_a  <= w_winner ? req1_a  : req0_a;
        r_ula_b  <= w_winner ? req1_b  : req0_b;
        r_ula_op <= w_winner ? req1_op : req0_op;
      end
      if (r_state == S_EXEC) begin
        r_rsp_s   <= ula_s;
        r_rsp_z   <= ula_z;
        r_rsp_err <= f_illegal(r_ula_op);
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == S_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_s     = r_rsp_s;
  assign rsp_z     = r_rsp_z;
  assign rsp_err   = r_rsp_err;
  assign ula_a     = r_ula_a;
  assign ula_b     = r_ula_b;
  assign ula_op    = r_ula_op;

endmodule
`default_nettype wire

// File: tb/tb_ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_arbiter
// Desc     : Directed and randomized bench for ula_arbiter with a behavioural
//            ULA and a transaction-level arbitration/result model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ula_arbiter;
  localparam int WIDTH = 32;
  localparam int OP_W  = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]  req0_op, req1_op;
  logic [WIDTH-1:0] rsp_s, ula_a, ula_b, ula_s;
  logic [OP_W-1:0]  ula_op;
  logic             rsp_z, rsp_err, ula_z;
  logic [WIDTH+1:0] ula_full;

  int tests = 0;
  int fails = 0;
  bit model_last;   // requester served most recently

  always #5 clock = ~clock;

  // Returns {err, z, s} for an operation as the ULA defines it.
  function automatic logic [WIDTH+1:0] ula_ref(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [OP_W-1:0] op);
    logic [WIDTH-1:0] s;
    logic ill;
    ill = 1'b0;
    case (op)
      4'd0:    s = a & b;
      4'd1:    s = a | b;
      4'd2:    s = a + b;
      4'd6:    s = a - b;
      4'd7:    s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   s = ~(a | b);
      default: begin s = '0; ill = 1'b1; end
    endcase
    return {ill, (s == '0), s};
  endfunction

  assign ula_full = ula_ref(ula_a, ula_b, ula_op);
  assign ula_s    = ula_full[WIDTH-1:0];
  assign ula_z    = ula_full[WIDTH];

  ula_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_s(ula_s), .ula_z(ula_z)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction, entered just after a falling edge in IDLE.
  task automatic txn(input logic [1:0] v,
                     input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                     input logic [OP_W-1:0] op0,
                     input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                     input logic [OP_W-1:0] op1,
                     input int hold, input bit keep, input string tag);
    bit               w;
    logic [WIDTH+1:0] e;
    logic [WIDTH-1:0] ea, eb;
    logic [OP_W-1:0]  eop;
    req0_a = a0; req0_b = b0; req0_op = op0;
    req1_a = a1; req1_b = b1; req1_op = op1;
    req_valid = v;
    #1;
    if (v == 2'b11) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = ~model_last;
`endif
    end else begin
      w = v[1];
    end
    model_last = w;
    ea  = w ? a1  : a0;
    eb  = w ? b1  : b0;
    eop = w ? op1 : op0;
    e   = ula_ref(ea, eb, eop);
    chk({tag, " grant"}, req_ready, w ? 2'b10 : 2'b01);
    @(negedge clock);
    chk({tag, " exec req_ready"}, req_ready, 2'b00);
    chk({tag, " exec rsp_valid"}, rsp_valid, 2'b00);
    chk({tag, " exec ula_a"}, ula_a, ea);
    chk({tag, " exec ula_b"}, ula_b, eb);
    chk({tag, " exec ula_op"}, ula_op, eop);
    @(negedge clock);
    chk({tag, " rsp_valid"}, rsp_valid, w ? 2'b10 : 2'b01);
    chk({tag, " rsp_s"}, rsp_s, e[WIDTH-1:0]);
    chk({tag, " rsp_z"}, rsp_z, e[WIDTH]);
    chk({tag, " rsp_err"}, rsp_err, e[WIDTH+1]);
    rsp_ready = w ? 2'b01 : 2'b10;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk($sformatf("%s hold%0d rsp_valid", tag, i), rsp_valid, w ? 2'b10 : 2'b01);
      chk($sformatf("%s hold%0d rsp_s", tag, i), rsp_s, e[WIDTH-1:0]);
      chk($sformatf("%s hold%0d req_ready", tag, i), req_ready, 2'b00);
    end
    rsp_ready = w ? 2'b10 : 2'b01;
    if (!keep) req_valid = 2'b00;
    @(negedge clock);
    rsp_ready = 2'b00;
    chk({tag, " done rsp_valid"}, rsp_valid, 2'b00);
    chk({tag, " idle ula_a hold"}, ula_a, ea);
    if (!keep) chk({tag, " idle req_ready"}, req_ready, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OP_W-1:0] ops [8];
    logic [1:0]      v;
    logic [WIDTH-1:0] ra0, rb0, ra1, rb1;
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};

    reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    model_last = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset req_ready", req_ready, 2'b00);
    chk("reset rsp_valid", rsp_valid, 2'b00);
    chk("reset rsp_s", rsp_s, '0);
    chk("reset rsp_z", rsp_z, 1'b0);
    chk("reset rsp_err", rsp_err, 1'b0);
    chk("reset ula_a", ula_a, '0);
    chk("reset ula_op", ula_op, '0);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset while EXEC: operation dropped, no response.
    req1_a = 32'd9; req1_b = 32'd4; req1_op = 4'd2; req_valid = 2'b10;
    #1 chk("rst-mid grant", req_ready, 2'b10);
    @(negedge clock);
    chk("rst-mid exec ula_a", ula_a, 32'd9);
    reset_n = 1'b0; req_valid = 2'b00;
    #1;
    chk("rst-mid ula_a", ula_a, '0);
    chk("rst-mid ula_op", ula_op, '0);
    chk("rst-mid rsp_s", rsp_s, '0);
    chk("rst-mid rsp_valid", rsp_valid, 2'b00);
    @(negedge clock);
    reset_n = 1'b1;
    model_last = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("rst-mid no rsp", rsp_valid, 2'b00);
    end

    // Contention: both valid continuously, grants 0,1,0,1.
    for (int k = 0; k < 4; k++)
      txn(2'b11, 32'd7, 32'd7, 4'd6, 32'd7, 32'd7, 4'd6, 0, 1'b1,
          $sformatf("contend%0d", k));
    req_valid = 2'b00;
    @(negedge clock);

    txn(2'b01, 32'd5, 32'd3, 4'd2, '0, '0, '0, 3, 1'b0, "add");
    txn(2'b10, '0, '0, '0, 32'hFFFF_FFFF, 32'd1, 4'd7, 0, 1'b0, "slt");
    txn(2'b01, 32'h1234, 32'h55, 4'd3, '0, '0, '0, 1, 1'b0, "illegal");
    txn(2'b01, 32'hF0F0, 32'h0FF0, 4'd0, '0, '0, '0, 0, 1'b0, "legal-after");

    // No request: nothing issues, ULA inputs hold.
    repeat (2) begin
      @(negedge clock);
      chk("noreq req_ready", req_ready, 2'b00);
      chk("noreq rsp_valid", rsp_valid, 2'b00);
      chk("noreq ula_a", ula_a, 32'hF0F0);
    end

    for (int k = 0; k < 40; k++) begin
      v   = 2'($urandom_range(1, 3));
      ra0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      ra1 = $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      txn(v, ra0, rb0, ops[$urandom_range(0, 7)], ra1, rb1, ops[$urandom_range(0, 7)],
          int'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0),
          $sformatf("rnd%0d", k));
    end
    req_valid = 2'b00;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
